// File: rtl/wb_memtest_pkg.sv
// Shared types and LFSR helpers for the Wishbone memory self-test initiator.
package wb_memtest_pkg;

  typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_e;
  typedef enum logic {WRITE, READ} phase_e;

  localparam logic [31:0] LFSR_POLY = 32'h04C1_1DB7;

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], 1'b0} ^ (l[31] ? LFSR_POLY : 32'h0);
  endfunction

  // An all-zero seed would lock the LFSR at zero.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/wb_memtest_lfsr.sv
// Pattern generator: load takes priority over step; holds value otherwise.
module wb_memtest_lfsr
  import wb_memtest_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        step_i,
  output logic [31:0] value_o
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)      lfsr_d = seed_fix(SEED);
    else if (step_i) lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= seed_fix(SEED);
    else       lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/wb_memtest_master.sv
// Wishbone classic initiator: writes an LFSR pattern over a word range, reads it back and compares.
// One access per REQ, outputs held until ack; a 1-cycle GAP separates accesses; optional ack timeout aborts.
module wb_memtest_master
  import wb_memtest_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned NUM_WORDS = 256,
  parameter logic [31:0] SEED      = 32'h0000_0001,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [15:0] err_count_o,
  output logic [31:0] first_err_adr_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  localparam int IW = $clog2(NUM_WORDS + 1);
  localparam int TW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [31:0]   BASE_W   = {BASE_ADDR[31:2], 2'b00};
  localparam logic [31:0]   SEED_EFF = seed_fix(SEED);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_WORDS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q;
  phase_e        phase_q;
  logic [IW-1:0] idx_q;
  logic [TW-1:0] tmo_q;
  logic          cyc_q, we_q, done_q, timeout_q;
  logic [31:0]   adr_q, dat_q, ferr_q;
  logic [15:0]   err_q;

  logic        lfsr_load, lfsr_step_en;
  logic [31:0] lfsr_val;
  logic        last_word, mismatch;

  assign last_word = (idx_q == IDX_LAST);
  assign mismatch  = (wbm_dat_i != lfsr_val);

  always_comb begin
    lfsr_load    = 1'b0;
    lfsr_step_en = 1'b0;
    if ((state_q == IDLE || state_q == DONE) && start_i) begin
      lfsr_load = 1'b1;
    end else if (state_q == REQ && wbm_ack_i) begin
      if (last_word && phase_q == WRITE) lfsr_load    = 1'b1;
      else                               lfsr_step_en = 1'b1;
    end
  end

  wb_memtest_lfsr #(.SEED(SEED_EFF)) u_lfsr (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step_en),
    .value_o (lfsr_val)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      phase_q   <= WRITE;
      idx_q     <= '0;
      tmo_q     <= '0;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      ferr_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            err_q     <= '0;
            ferr_q    <= '0;
            idx_q     <= '0;
            tmo_q     <= '0;
            phase_q   <= WRITE;
            cyc_q     <= 1'b1;
            we_q      <= 1'b1;
            adr_q     <= BASE_W;
            dat_q     <= SEED_EFF;
            state_q   <= REQ;
          end
        end
        REQ: begin
          // An ack in the expiry cycle still completes the access.
          if (wbm_ack_i) begin
            cyc_q <= 1'b0;
            if (phase_q == READ && mismatch) begin
              if (err_q != 16'hFFFF) err_q  <= err_q + 16'd1;
              if (err_q == 16'h0000) ferr_q <= adr_q;
            end
            if (!last_word) begin
              idx_q   <= idx_q + IW'(1);
              state_q <= GAP;
            end else if (phase_q == WRITE) begin
              idx_q   <= '0;
              phase_q <= READ;
              state_q <= GAP;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
            cyc_q     <= 1'b0;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        GAP: begin
          cyc_q   <= 1'b1;
          tmo_q   <= '0;
          we_q    <= (phase_q == WRITE);
          adr_q   <= BASE_W + (32'(idx_q) << 2);
          dat_q   <= lfsr_val;
          state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o          = (state_q == REQ) || (state_q == GAP);
  assign done_o          = done_q;
  assign pass_o          = done_q && (err_q == 16'h0000) && !timeout_q;
  assign timeout_o       = timeout_q;
  assign err_count_o     = err_q;
  assign first_err_adr_o = ferr_q;
  assign wbm_adr_o       = adr_q;
  assign wbm_dat_o       = dat_q;
  assign wbm_sel_o       = 4'hF;
  assign wbm_we_o        = we_q;
  assign wbm_cyc_o       = cyc_q;
  assign wbm_stb_o       = cyc_q;

endmodule

// File: tb/tb_wb_memtest_master.sv
// Scoreboard bench: two initiators, one on a 1-cycle registered-ack RAM, one on a 3-cycle-latency RAM.
`timescale 1ns/1ps
module tb_wb_memtest_master;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
  } acc_t;

  typedef struct {
    logic [15:0] err;
    logic [31:0] ferr;
    logic        pass;
    logic        tmo;
    int          cyc;
  } st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int tests = 0;
  int fails = 0;

  // Instance A: 4 words, seed 1, base 0
  logic        rst_a, start_a, busy_a, done_a, pass_a, tmo_a, we_a, cyc_a, stb_a, ack_a;
  logic [15:0] err_a;
  logic [31:0] ferr_a, adr_a, dat_a, rdat_a;
  logic [3:0]  sel_a;
  // Instance B: 8 words, wrapping base, seed with upper bits set
  logic        rst_b, start_b, busy_b, done_b, pass_b, tmo_b, we_b, cyc_b, stb_b, ack_b;
  logic [15:0] err_b;
  logic [31:0] ferr_b, adr_b, dat_b, rdat_b;
  logic [3:0]  sel_b;

  wb_memtest_master #(.BASE_ADDR(32'h0), .NUM_WORDS(4), .SEED(32'h1), .TIMEOUT(16)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst_a), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .pass_o(pass_a), .timeout_o(tmo_a), .err_count_o(err_a), .first_err_adr_o(ferr_a),
    .wbm_adr_o(adr_a), .wbm_dat_o(dat_a), .wbm_sel_o(sel_a), .wbm_we_o(we_a),
    .wbm_cyc_o(cyc_a), .wbm_stb_o(stb_a), .wbm_dat_i(rdat_a), .wbm_ack_i(ack_a));

  wb_memtest_master #(.BASE_ADDR(32'hFFFF_FFF3), .NUM_WORDS(8), .SEED(32'h4000_0000), .TIMEOUT(16)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst_b), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .pass_o(pass_b), .timeout_o(tmo_b), .err_count_o(err_b), .first_err_adr_o(ferr_b),
    .wbm_adr_o(adr_b), .wbm_dat_o(dat_b), .wbm_sel_o(sel_b), .wbm_we_o(we_b),
    .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b), .wbm_dat_i(rdat_b), .wbm_ack_i(ack_b));

  // RAM A: registered ack one cycle after the strobe; ack can be disabled; word 2 can be corrupted
  logic        ack_en = 1'b1;
  logic        corrupt = 1'b0;
  logic [31:0] mem_a [16];
  always @(posedge clk) begin
    if (rst_a) ack_a <= 1'b0;
    else begin
      ack_a <= cyc_a && stb_a && !ack_a && ack_en;
      if (cyc_a && stb_a && !ack_a && ack_en) begin
        if (we_a) mem_a[adr_a[5:2]] <= dat_a;
        rdat_a <= mem_a[adr_a[5:2]];
      end
      if (corrupt) mem_a[2] <= 32'hDEAD_BEEF;
    end
  end

  // RAM B: ack after three strobe cycles
  logic [31:0] mem_b [8];
  logic [1:0]  cnt_b;
  always @(posedge clk) begin
    if (rst_b) begin ack_b <= 1'b0; cnt_b <= 2'd0; end
    else if (ack_b) begin ack_b <= 1'b0; cnt_b <= 2'd0; end
    else if (cyc_b && stb_b) begin
      if (cnt_b == 2'd2) begin
        ack_b <= 1'b1;
        if (we_b) mem_b[adr_b[4:2]] <= dat_b;
        rdat_b <= mem_b[adr_b[4:2]];
      end else cnt_b <= cnt_b + 2'd1;
    end else cnt_b <= 2'd0;
  end

  // Hand-computed pattern tables
  logic [31:0] a_adr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] a_dat [4] = '{32'h1, 32'h2, 32'h4, 32'h8};
  logic [31:0] b_adr [8] = '{32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC,
                             32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
  logic [31:0] b_dat [8] = '{32'h4000_0000, 32'h8000_0000, 32'h04C1_1DB7, 32'h0982_3B6E,
                             32'h1304_76DC, 32'h2608_EDB8, 32'h4C11_DB70, 32'h9823_B6E0};

  acc_t exp_a[$], exp_b[$];
  st_t  st_a[$],  st_b[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  task automatic push_acc(input bit is_b, input int n, input int only_writes);
    acc_t x;
    for (int ph = 0; ph < 2; ph++)
      for (int i = 0; i < n; i++) begin
        if (ph == 1 && only_writes >= 0) break;
        if (only_writes >= 0 && i >= only_writes) break;
        x.adr = is_b ? b_adr[i] : a_adr[i];
        x.dat = is_b ? b_dat[i] : a_dat[i];
        x.we  = (ph == 0);
        if (is_b) exp_b.push_back(x); else exp_a.push_back(x);
      end
  endtask

  task automatic push_st(input bit is_b, input logic [15:0] e, input logic [31:0] f,
                         input logic p, input logic t, input int c);
    st_t s;
    s.err = e; s.ferr = f; s.pass = p; s.tmo = t; s.cyc = c;
    if (is_b) st_b.push_back(s); else st_a.push_back(s);
  endtask

  task automatic wait_done(input bit is_b, input int budget, input string nm);
    for (int i = 0; i < budget && !(is_b ? done_b : done_a); i++) @(negedge clk);
    tests++;
    if (!(is_b ? done_b : done_a)) begin
      fails++;
      $display("FAIL %s: done_o not seen within %0d cycles", nm, budget);
    end
  endtask

  // Monitor A
  logic done_a_prev = 1'b0;
  always @(negedge clk) begin
    if (cyc_a && stb_a && ack_a) begin
      if (exp_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_access: unexpected access adr %h we %b", adr_a, we_a);
      end else begin
        acc_t x;
        x = exp_a.pop_front();
        chk("a_adr", adr_a, x.adr);
        chk("a_dat", dat_a, x.dat);
        chk("a_we", {31'h0, we_a}, {31'h0, x.we});
      end
    end
    if (done_a && !done_a_prev) begin
      if (st_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_status: unexpected done_o at cycle %0d", cycle);
      end else begin
        st_t s;
        s = st_a.pop_front();
        chk("a_done_cycle", cycle, s.cyc);
        chk("a_err", {16'h0, err_a}, {16'h0, s.err});
        chk("a_ferr", ferr_a, s.ferr);
        chk("a_pass", {31'h0, pass_a}, {31'h0, s.pass});
        chk("a_timeout", {31'h0, tmo_a}, {31'h0, s.tmo});
      end
    end
    done_a_prev = done_a;
  end

  // Monitor B, plus request-stability tracking
  logic done_b_prev = 1'b0, prev_stb_b = 1'b0, prev_we_b = 1'b0;
  logic [31:0] prev_adr_b = 32'h0, prev_dat_b = 32'h0;
  int unstable_b = 0, acks_b = 0;
  always @(negedge clk) begin
    if (stb_b && prev_stb_b && (adr_b != prev_adr_b || dat_b != prev_dat_b || we_b != prev_we_b))
      unstable_b++;
    if (cyc_b && stb_b && ack_b) begin
      acks_b++;
      if (exp_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_access: unexpected access adr %h we %b", adr_b, we_b);
      end else begin
        acc_t x;
        x = exp_b.pop_front();
        chk("b_adr", adr_b, x.adr);
        chk("b_dat", dat_b, x.dat);
        chk("b_we", {31'h0, we_b}, {31'h0, x.we});
      end
    end
    if (done_b && !done_b_prev) begin
      if (st_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_status: unexpected done_o at cycle %0d", cycle);
      end else begin
        st_t s;
        s = st_b.pop_front();
        chk("b_done_cycle", cycle, s.cyc);
        chk("b_err", {16'h0, err_b}, {16'h0, s.err});
        chk("b_ferr", ferr_b, s.ferr);
        chk("b_pass", {31'h0, pass_b}, {31'h0, s.pass});
        chk("b_timeout", {31'h0, tmo_b}, {31'h0, s.tmo});
      end
    end
    done_b_prev = done_b;
    prev_stb_b = stb_b; prev_adr_b = adr_b; prev_dat_b = dat_b; prev_we_b = we_b;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, gaps;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_cyc", {31'h0, cyc_a}, 32'h0);
    chk("rst_stb", {31'h0, stb_a}, 32'h0);
    chk("rst_busy", {31'h0, busy_a}, 32'h0);
    chk("rst_done", {31'h0, done_a}, 32'h0);
    chk("rst_pass", {31'h0, pass_a}, 32'h0);
    chk("rst_adr", adr_a, 32'h0);
    chk("rst_sel", {28'h0, sel_a}, 32'hF);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // T1: clean run
    c0 = cycle;
    push_acc(1'b0, 4, -1);
    push_st(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, c0 + 24);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    chk("t1_cyc_after_start", {31'h0, cyc_a}, 32'h1);
    wait_done(1'b0, 60, "t1_done");

    // T2: corrupt word 2 between phases
    @(negedge clk);
    c0 = cycle;
    push_acc(1'b0, 4, -1);
    push_st(1'b0, 16'd1, 32'h8, 1'b0, 1'b0, c0 + 24);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 40 && !(cyc_a && !we_a); i++) @(negedge clk);
    corrupt = 1'b1; @(negedge clk); corrupt = 1'b0;
    wait_done(1'b0, 60, "t2_done");

    // T3: no ack -> timeout after 16 request cycles
    @(negedge clk);
    ack_en = 1'b0;
    c0 = cycle;
    push_st(1'b0, 16'd0, 32'h0, 1'b0, 1'b1, c0 + 17);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    n = 0;
    for (int i = 0; i < 60 && !done_a; i++) begin
      if (cyc_a) n++;
      @(negedge clk);
    end
    chk("t3_req_cycles", n, 16);
    chk("t3_cyc_low", {31'h0, cyc_a}, 32'h0);
    ack_en = 1'b1;

    // T4: reset during the third write
    @(negedge clk);
    push_acc(1'b0, 4, 2);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    for (int i = 0; i < 40 && !(cyc_a && we_a && adr_a == 32'h8); i++) @(negedge clk);
    rst_a = 1'b1; @(negedge clk); rst_a = 1'b0;
    chk("t4_cyc", {31'h0, cyc_a}, 32'h0);
    chk("t4_stb", {31'h0, stb_a}, 32'h0);
    chk("t4_adr", adr_a, 32'h0);
    chk("t4_dat", dat_a, 32'h0);
    chk("t4_busy", {31'h0, busy_a}, 32'h0);
    chk("t4_status", {done_a, tmo_a, pass_a, err_a, 13'h0}, 32'h0);
    n = 0;
    repeat (5) begin @(negedge clk); if (cyc_a || stb_a) n++; end
    chk("t4_quiet", n, 0);
    c0 = cycle;
    push_acc(1'b0, 4, -1);
    push_st(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, c0 + 24);
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    wait_done(1'b0, 60, "t4_done");

    // T5: start held high: one run while busy, restart straight from DONE
    @(negedge clk);
    c0 = cycle;
    push_acc(1'b0, 4, -1);
    push_st(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, c0 + 24);
    push_acc(1'b0, 4, -1);
    push_st(1'b0, 16'd0, 32'h0, 1'b1, 1'b0, c0 + 48);
    start_a = 1'b1;
    @(negedge clk);
    gaps = 0;
    for (int i = 0; i < 60 && !done_a; i++) begin
      if (busy_a && !stb_a) gaps++;
      @(negedge clk);
    end
    chk("t5_gap_cycles", gaps, 7);
    @(negedge clk);
    chk("t5_restart_cyc", {31'h0, cyc_a}, 32'h1);
    chk("t5_restart_done", {31'h0, done_a}, 32'h0);
    start_a = 1'b0;
    wait_done(1'b0, 60, "t5_done");

    // T6: 3-cycle ack latency, 8 words, wrapping addresses
    c0 = cycle;
    push_acc(1'b1, 8, -1);
    push_st(1'b1, 16'd0, 32'h0, 1'b1, 1'b0, c0 + 80);
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    wait_done(1'b1, 200, "t6_done");
    @(negedge clk);
    chk("t6_acks", acks_b, 16);
    chk("t6_unstable", unstable_b, 0);

    chk("a_queue_left", exp_a.size() + st_a.size(), 0);
    chk("b_queue_left", exp_b.size() + st_b.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
